// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;

    localparam logic [InstAddrBus-1:0] ZeroWord = '0;
    localparam logic [InstBus-1:0]     NopInst  = '0;

    // Fetch FSM encodings
    localparam logic [0:0] IF_FETCH = 1'b0;
    localparam logic [0:0] IF_READY = 1'b1;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
        logic                   excp;
    } ifid_t;

    // Sequential successor of a fetch address; wraps at 32 bits
    function automatic logic [InstAddrBus-1:0] seq_pc(input logic [InstAddrBus-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge port.
interface if_stage_if;
    import if_stage_pkg::*;

    logic                   req;
    logic [InstAddrBus-1:0] addr;
    logic                   ack;
    logic [InstBus-1:0]     rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush/bubble to NOP, hold on stall, else load.
module if_stage_if_id_reg
    import if_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  flush_i,
    input  logic  stall_i,
    input  logic  load_i,
    input  ifid_t load_data_i,
    output ifid_t ifid_o
);

    localparam ifid_t Bubble = '{pc: ZeroWord, inst: NopInst, excp: 1'b0};

    ifid_t ifid_q, ifid_d;

    // Next contents: flush beats stall; no delivered word means a bubble
    always_comb begin
        ifid_d = ifid_q;
        if (flush_i) begin
            ifid_d = Bubble;
        end else if (!stall_i) begin
            ifid_d = load_i ? load_data_i : Bubble;
        end
    end

    // Register with asynchronous reset to NOP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_q <= Bubble;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid_o = ifid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch FSM, branch/flush redirect, IF/ID register.
// Optional build macro IF_ALIGN_CHECK_EN adds fetch-address alignment checking.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned WAIT_MAX = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if_i,
    input  logic              stall_id_i,
    input  logic              branch_flag_i,
    input  logic [31:0]       branch_target_i,
    input  logic              flush_i,
    input  logic [31:0]       flush_pc_i,
    if_stage_if.master        imem,
    output logic [31:0]       id_pc_o,
    output logic [31:0]       id_inst_o,
    output logic              id_excp_o,
    output logic              stallreq_if_o
);

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic        drop_q, drop_d;

    logic        fetch_en;
    logic        ack_vld;
    logic        adv;
    logic        deliver;
    logic        br_take;
    logic        err_deliver;
    logic [31:0] next_pc;
    logic [31:0] deliver_inst;
    ifid_t       load_data;
    ifid_t       ifid;
    logic        unused_sig;

`ifdef IF_ALIGN_CHECK_EN
    logic err_q, err_d, err_sent_q, err_sent_d;

    assign fetch_en    = !err_q;
    assign err_deliver = err_q && !err_sent_q && !stall_if_i && !stall_id_i && !flush_i;
`else
    assign fetch_en    = 1'b1;
    assign err_deliver = 1'b0;
`endif

    assign imem.req      = (state_q == IF_FETCH) && fetch_en;
    assign imem.addr     = pc_q;
    // An ack only counts while a request is actually outstanding
    assign ack_vld       = imem.req && imem.ack;
    assign stallreq_if_o = !rst && (state_q == IF_FETCH) && imem.req && !imem.ack;

    // The current word leaves the stage (delivered or dropped) and the PC moves on
    assign adv     = !stall_if_i && (ack_vld || (state_q == IF_READY));
    assign deliver = adv && !drop_q;
    // A branch is ignored while a flush redirect is already queued
    assign br_take = branch_flag_i && !stall_id_i && !flush_i && !drop_q;

    assign deliver_inst = (state_q == IF_READY) ? hold_q : imem.rdata;

    // Redirect priority: flush, then queued redirect, then live branch, then sequential
    always_comb begin
        if (flush_i) begin
            next_pc = flush_pc_i;
        end else if (pend_q) begin
            next_pc = pend_addr_q;
        end else if (br_take) begin
            next_pc = branch_target_i;
        end else begin
            next_pc = seq_pc(pc_q);
        end
    end

    // FSM, PC and redirect bookkeeping
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_d      = hold_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        drop_d      = drop_q;
        if (adv) begin
            state_d = IF_FETCH;
            pc_d    = next_pc;
            pend_d  = 1'b0;
            drop_d  = 1'b0;
        end else begin
            if (ack_vld) begin
                // Acked under stall_if: park the word and drop the request
                state_d = IF_READY;
                hold_d  = imem.rdata;
            end
            if (flush_i) begin
                // Memory cannot abort: let the current word arrive, then discard it
                pend_d      = 1'b1;
                pend_addr_d = flush_pc_i;
                drop_d      = 1'b1;
            end else if (br_take) begin
                pend_d      = 1'b1;
                pend_addr_d = branch_target_i;
            end
        end
`ifdef IF_ALIGN_CHECK_EN
        if (err_q && flush_i) begin
            pc_d   = flush_pc_i;
            pend_d = 1'b0;
            drop_d = 1'b0;
        end
`endif
    end

    // Fetch state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IF_FETCH;
            pc_q        <= RESET_PC;
            hold_q      <= NopInst;
            pend_q      <= 1'b0;
            pend_addr_q <= ZeroWord;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            drop_q      <= drop_d;
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    // Misaligned PC: stop fetching, report once, wait for a flush
    always_comb begin
        err_d      = err_q;
        err_sent_d = err_sent_q;
        if (err_q && flush_i) begin
            err_d      = (flush_pc_i[1:0] != 2'b00);
            err_sent_d = 1'b0;
        end else if (adv && (next_pc[1:0] != 2'b00)) begin
            err_d      = 1'b1;
            err_sent_d = 1'b0;
        end else if (err_deliver) begin
            err_sent_d = 1'b1;
        end
    end

    // Alignment error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_sent_q <= 1'b0;
        end else begin
            err_q      <= err_d;
            err_sent_q <= err_sent_d;
        end
    end
`endif

    assign load_data = err_deliver ? '{pc: pc_q, inst: NopInst, excp: 1'b1}
                                   : '{pc: pc_q, inst: deliver_inst, excp: 1'b0};

    if_stage_if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .stall_i     (stall_id_i),
        .load_i      (deliver || err_deliver),
        .load_data_i (load_data),
        .ifid_o      (ifid)
    );

    assign id_pc_o   = ifid.pc;
    assign id_inst_o = ifid.inst;

`ifdef IF_ALIGN_CHECK_EN
    assign id_excp_o  = ifid.excp;
    assign unused_sig = ^WAIT_MAX;
`else
    assign id_excp_o  = 1'b0;
    assign unused_sig = ^{WAIT_MAX, ifid.excp};
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for the instruction-fetch stage.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall_if_i;
    logic        stall_id_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_excp_o;
    logic        stallreq_if_o;

    if_stage_if imem_bus ();

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall_if_i      (stall_if_i),
        .stall_id_i      (stall_id_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .imem            (imem_bus),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_excp_o       (id_excp_o),
        .stallreq_if_o   (stallreq_if_o)
    );

    // Memory returns the inverted address as the instruction word
    assign imem_bus.rdata = imem_bus.req ? ~imem_bus.addr : 32'hDEAD_BEEF;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ack;
        logic        sif;
        logic        sid;
        logic        br;
        logic [31:0] tgt;
        logic        fl;
        logic [31:0] fpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_sreq;
        logic        e_nop;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t v(logic ack, logic sif, logic sid, logic br, logic [31:0] tgt,
                               logic fl, logic [31:0] fpc, logic e_req, logic [31:0] e_addr,
                               logic e_sreq, logic e_nop, logic [31:0] e_pc);
        vec_t r;
        r.ack = ack; r.sif = sif; r.sid = sid; r.br = br; r.tgt = tgt; r.fl = fl; r.fpc = fpc;
        r.e_req = e_req; r.e_addr = e_addr; r.e_sreq = e_sreq; r.e_nop = e_nop; r.e_pc = e_pc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam logic [31:0] B = 32'h8000_0000;

    initial begin
        rst = 1'b1; stall_if_i = 0; stall_id_i = 0; branch_flag_i = 0; branch_target_i = 0;
        flush_i = 0; flush_pc_i = 0; imem_bus.ack = 0;

        //      ack sif sid br tgt       fl fpc               req addr            sreq nop pc
        // Back-to-back fetches
        tbl.push_back(v(1, 0, 0, 0, 0,       0, 0,            1, B,               0, 0, B));
        tbl.push_back(v(1, 0, 0, 0, 0,       0, 0,            1, B + 32'h04,      0, 0, B + 32'h04));
        tbl.push_back(v(1, 0, 0, 0, 0,       0, 0,            1, B + 32'h08,      0, 0, B + 32'h08));
        // Ack delayed three cycles
        tbl.push_back(v(0, 0, 0, 0, 0,       0, 0,            1, B + 32'h0C,      1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,       0, 0,            1, B + 32'h0C,      1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,       0, 0,            1, B + 32'h0C,      1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0,       0, 0,            1, B + 32'h0C,      0, 0, B + 32'h0C));
        // Branch with delay slot acked in the same cycle
        tbl.push_back(v(1, 0, 0, 0, 0,       0, 0,            1, B + 32'h10,      0, 0, B + 32'h10));
        tbl.push_back(v(1, 0, 0, 1, B+32'h100, 0, 0,          1, B + 32'h14,      0, 0, B + 32'h14));
        tbl.push_back(v(1, 0, 0, 0, 0,       0, 0,            1, B + 32'h100,     0, 0, B + 32'h100));
        // Flush mid-fetch: word dropped
        tbl.push_back(v(0, 0, 0, 0, 0,       1, B + 32'h180,  1, B + 32'h104,     1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,       0, 0,            1, B + 32'h104,     1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0,       0, 0,            1, B + 32'h104,     0, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0,       0, 0,            1, B + 32'h180,     0, 0, B + 32'h180));
        // Flush with ack in the same cycle, then branch during an outstanding fetch
        tbl.push_back(v(1, 0, 0, 0, 0,       1, B + 32'h10,   1, B + 32'h184,     0, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0,       0, 0,            1, B + 32'h10,      0, 0, B + 32'h10));
        tbl.push_back(v(0, 0, 0, 1, B+32'h100, 0, 0,          1, B + 32'h14,      1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0,       0, 0,            1, B + 32'h14,      0, 0, B + 32'h14));
        tbl.push_back(v(1, 0, 0, 0, 0,       0, 0,            1, B + 32'h100,     0, 0, B + 32'h100));
        // stall_if bubbles, held word delivered on release
        tbl.push_back(v(1, 1, 0, 0, 0,       0, 0,            1, B + 32'h104,     0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0,       0, 0,            0, B + 32'h104,     0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,       0, 0,            0, B + 32'h104,     0, 0, B + 32'h104));
        tbl.push_back(v(1, 0, 0, 0, 0,       0, 0,            1, B + 32'h108,     0, 0, B + 32'h108));
        // stall_id holds IF/ID; stray ack in READY ignored
        tbl.push_back(v(0, 1, 1, 0, 0,       0, 0,            1, B + 32'h10C,     1, 0, B + 32'h108));
        tbl.push_back(v(1, 1, 1, 0, 0,       0, 0,            1, B + 32'h10C,     0, 0, B + 32'h108));
        tbl.push_back(v(1, 0, 0, 0, 0,       0, 0,            0, B + 32'h10C,     0, 0, B + 32'h10C));
        // 32-bit PC wrap
        tbl.push_back(v(1, 0, 0, 0, 0,       1, 32'hFFFF_FFFC, 1, B + 32'h110,    0, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0,       0, 0,            1, 32'hFFFF_FFFC,   0, 0, 32'hFFFF_FFFC));
        tbl.push_back(v(1, 0, 0, 0, 0,       0, 0,            1, 32'h0000_0000,   0, 0, 32'h0000_0000));
        // Flush beats a simultaneous branch
        tbl.push_back(v(1, 0, 0, 1, B+32'h300, 1, B + 32'h400, 1, 32'h0000_0004,  0, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0,       0, 0,            1, B + 32'h400,     0, 0, B + 32'h400));

        // Reset state
        @(negedge clk);
        #1;
        chk("rst req", {31'd0, imem_bus.req}, 32'd1);
        chk("rst addr", imem_bus.addr, B);
        chk("rst stallreq", {31'd0, stallreq_if_o}, 32'd0);
        chk("rst id_pc", id_pc_o, 32'd0);
        chk("rst id_inst", id_inst_o, 32'd0);
        chk("rst id_excp", {31'd0, id_excp_o}, 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            imem_bus.ack    = tbl[i].ack;
            stall_if_i      = tbl[i].sif;
            stall_id_i      = tbl[i].sid;
            branch_flag_i   = tbl[i].br;
            branch_target_i = tbl[i].tgt;
            flush_i         = tbl[i].fl;
            flush_pc_i      = tbl[i].fpc;
            #1;
            chk($sformatf("v%0d req", i), {31'd0, imem_bus.req}, {31'd0, tbl[i].e_req});
            chk($sformatf("v%0d addr", i), imem_bus.addr, tbl[i].e_addr);
            chk($sformatf("v%0d stallreq", i), {31'd0, stallreq_if_o}, {31'd0, tbl[i].e_sreq});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d id_pc", i), id_pc_o, tbl[i].e_nop ? 32'd0 : tbl[i].e_pc);
            chk($sformatf("v%0d id_inst", i), id_inst_o, tbl[i].e_nop ? 32'd0 : ~tbl[i].e_pc);
            chk($sformatf("v%0d id_excp", i), {31'd0, id_excp_o}, 32'd0);
            @(negedge clk);
        end

        // Bounded wait for a held request to be acked
        imem_bus.ack = 0; stall_if_i = 0; stall_id_i = 0; branch_flag_i = 0; flush_i = 0;
        #1;
        begin
            int waited = 0;
            while (stallreq_if_o && waited < 4) begin
                chk($sformatf("wait%0d addr", waited), imem_bus.addr, B + 32'h404);
                @(negedge clk);
                waited++;
                if (waited == 3) imem_bus.ack = 1;
                #1;
            end
            chk("wait cycles", waited, 3);
        end
        @(posedge clk);
        #1;
        chk("wait id_pc", id_pc_o, B + 32'h404);
        chk("wait id_inst", id_inst_o, ~(B + 32'h404));

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        chk("arst addr", imem_bus.addr, B);
        chk("arst req", {31'd0, imem_bus.req}, 32'd1);
        chk("arst stallreq", {31'd0, stallreq_if_o}, 32'd0);
        chk("arst id_pc", id_pc_o, 32'd0);
        chk("arst id_inst", id_inst_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
